router_fsm: RTL and testbench

- Packet-level control FSM for the 1x3 router input side; it is the initiator that drives the synchronizer.
- It decodes the header address, tells the synchronizer when to latch the address (detect_add) and when to write (write_enb_reg).
- It reacts to the selected FIFO's full, empty and soft-reset indications, and sequences the register block through header, payload, parity and parity-check phases.

---
 rtl/router_fsm.sv | 180 ++++++++++++++++++
 tb/tb_router_fsm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Input-side packet controller for the 1x3 router: decodes the destination
// address and sequences the synchronizer and register block through a packet.
//
// state              | meaning
// -------------------+---------------------------------------------------------
// DECODE_ADDRESS     | idle; watch the header byte for a valid destination
// WAIT_TILL_EMPTY    | destination FIFO still draining; hold the source off
// LOAD_FIRST_DATA    | write the header byte into the destination FIFO
// LOAD_DATA          | write payload bytes until pkt_valid falls
// FIFO_FULL_STATE    | destination FIFO full; hold the current byte
// LOAD_AFTER_FULL    | write the byte that was held while full
// LOAD_PARITY        | write the parity byte
// CHECK_PARITY_ERROR | evaluate and clear the internal parity register
module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       write_enb_reg,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [1:0] port_idx;
  logic       addr_ok;
  logic       sel_empty;
  logic       sel_soft_reset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // The header byte is still on data_in while decoding; afterwards the
  // latched address selects the port.
  assign port_idx = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
  assign addr_ok  = (data_in != 2'b11);

  always_comb begin
    sel_empty      = 1'b0;
    sel_soft_reset = 1'b0;
    case (port_idx)
      2'd0: begin
        sel_empty      = fifo_empty_0;
        sel_soft_reset = soft_reset_0;
      end
      2'd1: begin
        sel_empty      = fifo_empty_1;
        sel_soft_reset = soft_reset_1;
      end
      2'd2: begin
        sel_empty      = fifo_empty_2;
        sel_soft_reset = soft_reset_2;
      end
      default: begin
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
      end
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && pkt_valid && addr_ok) begin
      addr_d = data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid && addr_ok) begin
          state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A read timeout on the active port abandons the packet from any state.
    if (state_q != DECODE_ADDRESS && sel_soft_reset) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    write_enb_reg = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    full_state    = 1'b0;
    laf_state     = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state_q)
      DECODE_ADDRESS:  detect_add = 1'b1;
      WAIT_TILL_EMPTY: busy       = 1'b1;
      LOAD_FIRST_DATA: begin
        lfd_state     = 1'b1;
        busy          = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        busy          = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        busy          = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      default: detect_add = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus queues the expected output vector
// for each cycle, a negedge monitor pops and compares against the DUT.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, write_enb_reg, lfd_state, ld_state;
  logic       full_state, laf_state, rst_int_reg, busy;

  typedef enum int {S_DA, S_WTE, S_LFD, S_LD, S_FULL, S_LAF, S_LP, S_CPE} st_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  router_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .write_enb_reg (write_enb_reg),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy)
  );

  // {detect_add, write_enb_reg, lfd, ld, full, laf, rst_int_reg, busy}
  function automatic logic [7:0] exp_out(st_t s);
    case (s)
      S_DA:    return 8'b1000_0000;
      S_WTE:   return 8'b0000_0001;
      S_LFD:   return 8'b0110_0001;
      S_LD:    return 8'b0101_0000;
      S_FULL:  return 8'b0000_1001;
      S_LAF:   return 8'b0100_0101;
      S_LP:    return 8'b0100_0001;
      S_CPE:   return 8'b0000_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] dut_out();
    return {detect_add, write_enb_reg, lfd_state, ld_state,
            full_state, laf_state, rst_int_reg, busy};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and queue the outputs expected in the new state.
  task automatic tick(input st_t s, input string name);
    sb_item_t it;
    @(posedge clk);
    #1;
    it.name = name;
    it.exp  = exp_out(s);
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    sb_item_t it;
    if (sb.size() != 0) begin
      it = sb.pop_front();
      check(it.name, dut_out(), it.exp);
    end
  end

  initial begin
    rst = 1'b1;
    pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;

    tick(S_DA, "reset_state");
    rst = 1'b0;

    // Basic packet to port 1
    pkt_valid = 1'b1; data_in = 2'b01; fifo_empty_1 = 1'b1;
    tick(S_LFD, "p1_lfd");
    tick(S_LD,  "p1_ld0");
    tick(S_LD,  "p1_ld1");
    pkt_valid = 1'b0;
    tick(S_LP,  "p1_parity");
    tick(S_CPE, "p1_check");
    tick(S_DA,  "p1_decode");
    tick(S_DA,  "p1_idle");

    // Port 2 busy for 5 cycles, then full stall and low_pkt_valid exit
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
    for (int i = 0; i < 5; i++) tick(S_WTE, "p2_wait");
    fifo_empty_2 = 1'b1;
    tick(S_LFD, "p2_lfd");
    tick(S_LD,  "p2_ld");
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) tick(S_FULL, "p2_full");
    fifo_full = 1'b0;
    tick(S_LAF, "p2_laf");
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    tick(S_LP,  "p2_lowpkt_parity");
    low_pkt_valid = 1'b0;
    tick(S_CPE, "p2_check");
    tick(S_DA,  "p2_decode");

    // Full has priority over pkt_valid falling; parity_done exit from LAF
    pkt_valid = 1'b1; data_in = 2'b10;
    tick(S_LFD, "p3_lfd");
    tick(S_LD,  "p3_ld");
    pkt_valid = 1'b0; fifo_full = 1'b1;
    tick(S_FULL, "p3_full_prio");
    fifo_full = 1'b0;
    tick(S_LAF, "p3_laf");
    parity_done = 1'b1;
    tick(S_DA,  "p3_parity_done");
    parity_done = 1'b0;
    tick(S_DA,  "p3_idle");

    // Invalid address 2'b11 is dropped and addr_q keeps 2
    pkt_valid = 1'b1; data_in = 2'b11;
    tick(S_DA, "inv_addr0");
    tick(S_DA, "inv_addr1");
    check("addr_hold", {6'd0, dut.addr_q}, 8'd2);
    pkt_valid = 1'b0;

    // Soft reset: only the latched port's timeout matters
    pkt_valid = 1'b1; data_in = 2'b00; fifo_empty_0 = 1'b0;
    tick(S_WTE, "sr_wait");
    pkt_valid = 1'b0; data_in = 2'b01; soft_reset_1 = 1'b1;
    tick(S_WTE, "sr_other_port");
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    tick(S_DA,  "sr_own_port");
    soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
    tick(S_DA,  "sr_idle");

    // Asynchronous reset in LOAD_DATA
    pkt_valid = 1'b1; data_in = 2'b01;
    tick(S_LFD, "ar_lfd");
    tick(S_LD,  "ar_ld");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", dut_out(), exp_out(S_DA));
    pkt_valid = 1'b0;
    tick(S_DA, "ar_held");
    rst = 1'b0;
    tick(S_DA, "ar_released");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
